// File: rtl/fetch_req_buffer.sv
// rtl/fetch_req_buffer.sv - fetch request issue FSM with an in-order instruction buffer
//
// Purpose:
//   Takes fetch addresses from the PC generator, issues at most one request
//   at a time to the icache interface, and queues the returned instruction
//   words (with their PC and page-fault flag) for decode. A slot is reserved
//   before a request is issued, so a response always has somewhere to go.
//   A redirect (flush_i) kills the outstanding request and empties the buffer;
//   the killed response, if it has not arrived yet, is swallowed in DRAIN.
//
// Ports:
//   clk_i, rstn_i          clock (rising edge), asynchronous active-low reset
//   pc_valid_i, pc_i       fetch address offered by the PC generator
//   pc_ready_o             offered address accepted (request issued) this cycle
//   flush_i                redirect: kill in-flight fetch, empty the buffer
//   flush_icache_i         fence.i: forwarded as invalidate_icache
//   req_fetch_icache_o     request to the icache interface
//   req_fetch_ready_i      icache interface can take a request
//   resp_icache_fetch_i    icache response (valid, data, instr_page_fault)
//   instr_valid_o, instr_o, instr_pc_o, instr_pf_o
//                          head entry presented to decode
//   instr_ready_i          decode pops the head entry
//
// Optional feature:
//   FETCH_BUF_BYPASS_EN    when defined, a response arriving while the buffer
//                          is empty is presented to decode in the same cycle,
//                          and is only written if decode does not take it.

package fetch_req_buffer_pkg;

  localparam int PHY_VIRT_MAX_ADDR_SIZE = 40;

  typedef struct packed {
    logic                              valid;
    logic [PHY_VIRT_MAX_ADDR_SIZE-1:0] vaddr;
    logic                              invalidate_icache;
    logic                              invalidate_buffer;
    logic                              inval_fetch;
  } req_cpu_icache_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    logic        instr_page_fault;
  } resp_icache_cpu_t;

endpackage

module fetch_req_buffer
  import fetch_req_buffer_pkg::*;
#(
  // Entry count; power of two, at least 2.
  parameter int DEPTH = 4
) (
  input  logic                              clk_i,
  input  logic                              rstn_i,

  input  logic                              pc_valid_i,
  input  logic [PHY_VIRT_MAX_ADDR_SIZE-1:0] pc_i,
  output logic                              pc_ready_o,

  input  logic                              flush_i,
  input  logic                              flush_icache_i,

  output req_cpu_icache_t                   req_fetch_icache_o,
  input  logic                              req_fetch_ready_i,
  input  resp_icache_cpu_t                  resp_icache_fetch_i,

  output logic                              instr_valid_o,
  output logic [31:0]                       instr_o,
  output logic [PHY_VIRT_MAX_ADDR_SIZE-1:0] instr_pc_o,
  output logic                              instr_pf_o,
  input  logic                              instr_ready_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_RESP = 2'd1;
  localparam logic [1:0] DRAIN     = 2'd2;

  logic [1:0]                        state;
  logic [1:0]                        state_next;
  logic [PHY_VIRT_MAX_ADDR_SIZE-1:0] pend_pc;

  logic [PTR_W-1:0]                  rd_ptr;
  logic [PTR_W-1:0]                  wr_ptr;
  logic [CNT_W-1:0]                  count;

  logic [31:0]                       mem_data [DEPTH];
  logic [PHY_VIRT_MAX_ADDR_SIZE-1:0] mem_pc   [DEPTH];
  logic [DEPTH-1:0]                  mem_pf;

  logic        buf_empty;
  logic        issue;
  logic        resp_take;
  logic        kill;
  logic        push;
  logic        pop;
  logic [31:0] resp_data;

  assign buf_empty = (count == '0);

  // Issue only with a free slot so the eventual response can always be
  // pushed. rstn_i gates it so nothing leaks out while reset is held.
  assign issue = rstn_i & (state == IDLE) & pc_valid_i & req_fetch_ready_i &
                 ~flush_i & (count < FULL_CNT);

  // A response is kept only in WAIT_RESP and only if no redirect kills it
  // in the same cycle.
  assign resp_take = (state == WAIT_RESP) & resp_icache_fetch_i.valid & ~flush_i;
  assign kill      = (state == WAIT_RESP) & flush_i;

  // Faulting fetches carry no usable instruction bits.
  assign resp_data = resp_icache_fetch_i.instr_page_fault ? 32'd0
                                                          : resp_icache_fetch_i.data;

`ifdef FETCH_BUF_BYPASS_EN
  logic bypass;
  assign bypass = resp_take & buf_empty;
  // Decode consumed the bypassed word directly; do not store it.
  assign push   = resp_take & ~(bypass & instr_ready_i);
`else
  assign push   = resp_take;
`endif

  // With bypass the buffer is empty, so this never pops the buffer itself.
  assign pop = ~buf_empty & instr_ready_i;

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (issue) state_next = WAIT_RESP;
      end
      WAIT_RESP: begin
        // A response coinciding with a flush is dropped here, so there is
        // nothing left to drain.
        if (resp_icache_fetch_i.valid) state_next = IDLE;
        else if (flush_i)              state_next = DRAIN;
      end
      DRAIN: begin
        if (resp_icache_fetch_i.valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state   <= IDLE;
      pend_pc <= '0;
    end else begin
      state <= state_next;
      if (issue) pend_pc <= pc_i;
    end
  end

  // ---------------------------------------------------------- pointers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      // Redirect wins over any same-cycle push or pop.
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // ----------------------------------------------------------- storage
  // Entries need no reset: they are only visible while count covers them.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_data[wr_ptr] <= resp_data;
      mem_pc[wr_ptr]   <= pend_pc;
      mem_pf[wr_ptr]   <= resp_icache_fetch_i.instr_page_fault;
    end
  end

  // ----------------------------------------------------------- outputs
  always_comb begin
    req_fetch_icache_o                   = '0;
    req_fetch_icache_o.valid             = issue;
    req_fetch_icache_o.vaddr             = issue ? pc_i : '0;
    req_fetch_icache_o.invalidate_icache = rstn_i & flush_icache_i;
    req_fetch_icache_o.invalidate_buffer = kill;
    req_fetch_icache_o.inval_fetch       = kill;
  end

  assign pc_ready_o = issue;

  // Head fields are zeroed when nothing is valid so reset and empty states
  // present clean outputs.
  always_comb begin
    instr_valid_o = ~buf_empty;
    instr_o       = buf_empty ? 32'd0 : mem_data[rd_ptr];
    instr_pc_o    = buf_empty ? '0    : mem_pc[rd_ptr];
    instr_pf_o    = ~buf_empty & mem_pf[rd_ptr];
`ifdef FETCH_BUF_BYPASS_EN
    if (bypass) begin
      instr_valid_o = 1'b1;
      instr_o       = resp_data;
      instr_pc_o    = pend_pc;
      instr_pf_o    = resp_icache_fetch_i.instr_page_fault;
    end
`endif
  end

endmodule

// File: tb/tb_fetch_req_buffer.sv
// tb/tb_fetch_req_buffer.sv - directed self-checking bench for fetch_req_buffer
module tb_fetch_req_buffer;
  import fetch_req_buffer_pkg::*;

  localparam int AW = PHY_VIRT_MAX_ADDR_SIZE;
  localparam logic [AW-1:0] BASE = 40'h00_8000_1000;

  logic             clk = 1'b0;
  logic             rstn;
  logic             pc_valid;
  logic [AW-1:0]    pc;
  logic             pc_ready;
  logic             flush;
  logic             flush_icache;
  req_cpu_icache_t  req;
  logic             req_ready;
  resp_icache_cpu_t resp;
  logic             instr_valid;
  logic [31:0]      instr;
  logic [AW-1:0]    instr_pc;
  logic             instr_pf;
  logic             instr_ready;

  int n_tests = 0;
  int n_fail  = 0;

  int issued;
  int rcnt;
  logic pend;

  always #5 clk = ~clk;

  fetch_req_buffer #(.DEPTH(4)) dut (
    .clk_i               (clk),
    .rstn_i              (rstn),
    .pc_valid_i          (pc_valid),
    .pc_i                (pc),
    .pc_ready_o          (pc_ready),
    .flush_i             (flush),
    .flush_icache_i      (flush_icache),
    .req_fetch_icache_o  (req),
    .req_fetch_ready_i   (req_ready),
    .resp_icache_fetch_i (resp),
    .instr_valid_o       (instr_valid),
    .instr_o             (instr),
    .instr_pc_o          (instr_pc),
    .instr_pf_o          (instr_pf),
    .instr_ready_i       (instr_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic idle_inputs;
    pc_valid     = 1'b0;
    flush        = 1'b0;
    flush_icache = 1'b0;
    resp         = '0;
    instr_ready  = 1'b0;
    req_ready    = 1'b1;
  endtask

  initial begin
    // Reset with busy-looking inputs: every output must still be 0.
    rstn         = 1'b0;
    pc_valid     = 1'b1;
    pc           = 40'h80000000;
    req_ready    = 1'b1;
    flush        = 1'b0;
    flush_icache = 1'b1;
    resp         = '0;
    instr_ready  = 1'b1;
    #12;
    settle;
    check("rst_pc_ready",    64'(pc_ready),    64'd0);
    check("rst_req",         64'(req),         64'd0);
    check("rst_instr_valid", 64'(instr_valid), 64'd0);
    check("rst_instr",       64'(instr),       64'd0);
    check("rst_instr_pc",    64'(instr_pc),    64'd0);
    check("rst_instr_pf",    64'(instr_pf),    64'd0);

    next_cycle;
    rstn = 1'b1;
    idle_inputs;

    // Basic fetch, response two cycles after issue.
    next_cycle;
    pc_valid     = 1'b1;
    pc           = 40'h80000000;
    flush_icache = 1'b1;
    settle;
    check("basic_pc_ready",  64'(pc_ready),  64'd1);
    check("basic_req_valid", 64'(req.valid), 64'd1);
    check("basic_vaddr",     64'(req.vaddr), 64'h80000000);
    check("basic_inv_icache", 64'(req.invalidate_icache), 64'd1);
    next_cycle;
    flush_icache = 1'b0;
    pc           = BASE;
    settle;
    check("one_outstanding_ready", 64'(pc_ready),  64'd0);
    check("one_outstanding_req",   64'(req.valid), 64'd0);
    next_cycle;
    pc_valid   = 1'b0;
    resp.valid = 1'b1;
    resp.data  = 32'h00000013;
    settle;
    check("lat_not_early", 64'(instr_valid), 64'd0);
    next_cycle;
    resp = '0;
    settle;
    check("basic_valid", 64'(instr_valid), 64'd1);
    check("basic_instr", 64'(instr),       64'h13);
    check("basic_pc",    64'(instr_pc),    64'h80000000);
    check("basic_pf",    64'(instr_pf),    64'd0);
    instr_ready = 1'b1;
    next_cycle;
    instr_ready = 1'b0;
    settle;
    check("pop_empty", 64'(instr_valid), 64'd0);

    // Back-pressure: decode stalled, six PCs offered, one-cycle responder.
    next_cycle;
    issued = 0;
    rcnt   = 0;
    pend   = 1'b0;
    for (int c = 0; c < 16; c++) begin
      pc_valid   = (issued < 6);
      pc         = BASE + AW'(4 * issued);
      resp.valid = pend;
      resp.data  = 32'h1000 + 32'(rcnt);
      settle;
      if (pend) rcnt++;
      pend = pc_ready;
      if (pc_ready) issued++;
      next_cycle;
    end
    resp = '0;
    check("bp_issues",    64'(issued), 64'd4);
    check("bp_responses", 64'(rcnt),   64'd4);
    pc_valid = 1'b1;
    pc       = BASE + AW'(16);
    settle;
    check("bp_full_stall", 64'(pc_ready), 64'd0);
    check("bp_head_pc",    64'(instr_pc), 64'(BASE));
    check("bp_head_data",  64'(instr),    64'h1000);
    next_cycle;
    instr_ready = 1'b1;
    settle;
    check("bp_pop_cycle_stall", 64'(pc_ready), 64'd0);
    next_cycle;
    instr_ready = 1'b0;
    settle;
    check("bp_reissue",      64'(pc_ready),  64'd1);
    check("bp_reissue_addr", 64'(req.vaddr), 64'(BASE + AW'(16)));
    next_cycle;
    pc_valid   = 1'b0;
    resp.valid = 1'b1;
    resp.data  = 32'h1004;
    next_cycle;
    resp        = '0;
    instr_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      settle;
      check("bp_drain_valid", 64'(instr_valid), 64'd1);
      check("bp_drain_pc",    64'(instr_pc),    64'(BASE + AW'(4 * i)));
      check("bp_drain_data",  64'(instr),       64'(32'h1000 + 32'(i)));
      next_cycle;
    end
    instr_ready = 1'b0;
    settle;
    check("bp_empty", 64'(instr_valid), 64'd0);

    // Flush while waiting, with one entry already buffered.
    next_cycle;
    pc_valid = 1'b1;
    pc       = BASE + AW'(32'h100);
    next_cycle;
    pc_valid   = 1'b0;
    resp.valid = 1'b1;
    resp.data  = 32'h55;
    next_cycle;
    resp = '0;
    settle;
    check("fl_pre_valid", 64'(instr_valid), 64'd1);
    check("fl_pre_pc",    64'(instr_pc),    64'(BASE + AW'(32'h100)));
    pc_valid = 1'b1;
    pc       = BASE + AW'(32'h104);
    settle;
    check("fl_issue", 64'(pc_ready), 64'd1);
    next_cycle;
    pc    = BASE + AW'(32'h108);
    flush = 1'b1;
    settle;
    check("fl_kill",     64'(req.inval_fetch),       64'd1);
    check("fl_inv_buf",  64'(req.invalidate_buffer), 64'd1);
    check("fl_no_issue", 64'(pc_ready),              64'd0);
    next_cycle;
    flush = 1'b0;
    settle;
    check("fl_cleared",     64'(instr_valid), 64'd0);
    check("fl_drain_stall", 64'(pc_ready),    64'd0);
    next_cycle;
    settle;
    check("fl_drain_stall2", 64'(pc_ready), 64'd0);
    next_cycle;
    resp.valid = 1'b1;
    resp.data  = 32'h66;
    settle;
    check("fl_drain_resp_stall", 64'(pc_ready), 64'd0);
    next_cycle;
    resp = '0;
    settle;
    check("fl_resp_dropped", 64'(instr_valid), 64'd0);
    check("fl_idle_issue",   64'(pc_ready),    64'd1);
    check("fl_idle_addr",    64'(req.vaddr),   64'(BASE + AW'(32'h108)));

    // Flush coincident with the response.
    next_cycle;
    pc         = BASE + AW'(32'h10C);
    flush      = 1'b1;
    resp.valid = 1'b1;
    resp.data  = 32'h77;
    settle;
    check("co_kill",     64'(req.inval_fetch), 64'd1);
    check("co_no_issue", 64'(pc_ready),        64'd0);
    next_cycle;
    flush = 1'b0;
    resp  = '0;
    settle;
    check("co_next_issue", 64'(pc_ready),    64'd1);
    check("co_next_addr",  64'(req.vaddr),   64'(BASE + AW'(32'h10C)));
    check("co_no_push",    64'(instr_valid), 64'd0);

    // Page-fault response.
    next_cycle;
    pc_valid                  = 1'b0;
    resp.valid                = 1'b1;
    resp.data                 = 32'hDEADBEEF;
    resp.instr_page_fault     = 1'b1;
    next_cycle;
    resp = '0;
    settle;
    check("pf_valid", 64'(instr_valid), 64'd1);
    check("pf_flag",  64'(instr_pf),    64'd1);
    check("pf_data",  64'(instr),       64'd0);
    check("pf_pc",    64'(instr_pc),    64'(BASE + AW'(32'h10C)));

    // Reset mid-transaction, with an entry still buffered.
    pc_valid = 1'b1;
    pc       = BASE + AW'(32'h200);
    settle;
    check("rm_issue", 64'(pc_ready), 64'd1);
    next_cycle;
    flush        = 1'b1;
    flush_icache = 1'b1;
    #2;
    rstn = 1'b0;
    #1;
    check("rm_pc_ready",    64'(pc_ready),    64'd0);
    check("rm_req",         64'(req),         64'd0);
    check("rm_instr_valid", 64'(instr_valid), 64'd0);
    check("rm_instr",       64'(instr),       64'd0);
    check("rm_instr_pc",    64'(instr_pc),    64'd0);
    check("rm_instr_pf",    64'(instr_pf),    64'd0);
    next_cycle;
    next_cycle;
    rstn = 1'b1;
    idle_inputs;
    next_cycle;
    resp.valid = 1'b1;
    resp.data  = 32'h99;
    settle;
    check("rm_late_resp", 64'(instr_valid), 64'd0);
    next_cycle;
    resp = '0;
    settle;
    check("rm_ignored", 64'(instr_valid), 64'd0);
    next_cycle;
    settle;
    check("rm_ignored2", 64'(instr_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
